// File: rtl/program_loader.sv
// Frame-driven instruction memory loader: assembles little-endian halfwords from a
// byte stream, writes them to program memory and releases the core on a good checksum.
module program_loader #(
   parameter int unsigned MAX_HALFWORDS = 512,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_ready_o,
   input  logic        load_start_i,
   output logic        program_mem_write_en_o,
   output logic [31:0] instruction_addr_o,
   output logic [15:0] instruction_o,
   output logic        cpu_hold_o,
   output logic        load_done_o,
   output logic        load_error_o
);

   typedef enum logic [3:0] {
      SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  len_lo_q;
   logic [7:0]  data_lo_q;
   logic [7:0]  checksum_q;
   logic [15:0] remaining_q;
   logic        accept;
   logic [15:0] len;

   assign accept = byte_valid_i && byte_ready_o;
   assign len    = {byte_i, len_lo_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    if (accept && byte_i == SYNC_BYTE) state_d = LEN_LO;
         LEN_LO:  if (accept) state_d = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if ({16'h0000, len} > MAX_HALFWORDS) state_d = ERROR;
               else if (len == 16'h0000)            state_d = CHECK;
               else                                 state_d = DATA_LO;
            end
         end
         DATA_LO: if (accept) state_d = DATA_HI;
         DATA_HI: if (accept) state_d = WRITE;
         WRITE:   state_d = (remaining_q == 16'd1) ? CHECK : DATA_LO;
         CHECK:   if (accept) state_d = (byte_i == checksum_q) ? DONE : ERROR;
         DONE,
         ERROR:   if (load_start_i) state_d = SYNC;
         default: state_d = SYNC;
      endcase
   end

   // Status outputs are registered decodes of the next state so they line up
   // with the state they describe and never depend combinationally on inputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q                <= SYNC;
         byte_ready_o           <= 1'b1;
         program_mem_write_en_o <= 1'b0;
         instruction_addr_o     <= BASE_ADDR;
         instruction_o          <= '0;
         cpu_hold_o             <= 1'b1;
         load_done_o            <= 1'b0;
         load_error_o           <= 1'b0;
         len_lo_q               <= '0;
         data_lo_q              <= '0;
         checksum_q             <= '0;
         remaining_q            <= '0;
      end else begin
         state_q                <= state_d;
         byte_ready_o           <= !(state_d inside {WRITE, DONE, ERROR});
         program_mem_write_en_o <= (state_d == WRITE);
         cpu_hold_o             <= (state_d != DONE);
         load_done_o            <= (state_d == DONE);
         load_error_o           <= (state_d == ERROR);
         case (state_q)
            LEN_LO: if (accept) len_lo_q <= byte_i;
            LEN_HI: begin
               if (accept && state_d == DATA_LO) begin
                  remaining_q        <= len;
                  instruction_addr_o <= BASE_ADDR;
               end
            end
            DATA_LO: begin
               if (accept) begin
                  data_lo_q  <= byte_i;
                  checksum_q <= checksum_q ^ byte_i;
               end
            end
            DATA_HI: begin
               if (accept) begin
                  instruction_o <= {byte_i, data_lo_q};
                  checksum_q    <= checksum_q ^ byte_i;
               end
            end
            WRITE: begin
               remaining_q        <= remaining_q - 16'd1;
               instruction_addr_o <= instruction_addr_o + 32'd2;
            end
            DONE, ERROR: if (load_start_i) checksum_q <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are streamed through the handshake and
// every write strobe is captured for comparison against hand-computed expectations.
module tb_program_loader;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_i = '0;
   logic        byte_ready_o;
   logic        load_start_i = 1'b0;
   logic        program_mem_write_en_o;
   logic [31:0] instruction_addr_o;
   logic [15:0] instruction_o;
   logic        cpu_hold_o;
   logic        load_done_o;
   logic        load_error_o;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned cyc    = 0;
   int unsigned ready_in_write = 0;

   logic [31:0] st_addr[$];
   logic [15:0] st_data[$];
   int unsigned st_cyc[$];
   logic [15:0] words[512];

   program_loader #(
      .MAX_HALFWORDS(512),
      .BASE_ADDR    (32'h0000_0000),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk_i                 (clk_i),
      .reset_n_i             (reset_n_i),
      .byte_valid_i          (byte_valid_i),
      .byte_i                (byte_i),
      .byte_ready_o          (byte_ready_o),
      .load_start_i          (load_start_i),
      .program_mem_write_en_o(program_mem_write_en_o),
      .instruction_addr_o    (instruction_addr_o),
      .instruction_o         (instruction_o),
      .cpu_hold_o            (cpu_hold_o),
      .load_done_o           (load_done_o),
      .load_error_o          (load_error_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (program_mem_write_en_o) begin
         st_addr.push_back(instruction_addr_o);
         st_data.push_back(instruction_o);
         st_cyc.push_back(cyc);
         if (byte_ready_o) ready_in_write = ready_in_write + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge after the byte transferred.
   task automatic send(input logic [7:0] b);
      int unsigned waited = 0;
      while (!byte_ready_o && waited < 100) begin
         @(negedge clk_i);
         waited++;
      end
      if (!byte_ready_o) check("ready_timeout", 32'(byte_ready_o), 32'd1);
      byte_valid_i = 1'b1;
      byte_i       = b;
      @(negedge clk_i);
   endtask

   task automatic idle(input int unsigned n);
      byte_valid_i = 1'b0;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic rearm();
      byte_valid_i = 1'b0;
      load_start_i = 1'b1;
      @(negedge clk_i);
      load_start_i = 1'b0;
   endtask

   task automatic clear_log();
      st_addr.delete();
      st_data.delete();
      st_cyc.delete();
   endtask

   initial begin
      logic [7:0]  ck;
      int unsigned bad;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst_ready", 32'(byte_ready_o), 32'd1);
      check("rst_we",    32'(program_mem_write_en_o), 32'd0);
      check("rst_addr",  instruction_addr_o, 32'h0);
      check("rst_instr", 32'(instruction_o), 32'h0);
      check("rst_hold",  32'(cpu_hold_o), 32'd1);
      check("rst_done",  32'(load_done_o), 32'd0);
      check("rst_err",   32'(load_error_o), 32'd0);
      reset_n_i = 1'b1;
      @(negedge clk_i);

      // Good two-halfword frame
      clear_log();
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      check("f1_done_before_chk", 32'(load_done_o), 32'd0);
      send(8'h08);
      check("f1_strobes", st_addr.size(), 32'd2);
      if (st_addr.size() == 2) begin
         check("f1_addr0", st_addr[0], 32'h0);
         check("f1_data0", 32'(st_data[0]), 32'h1234);
         check("f1_addr1", st_addr[1], 32'h2);
         check("f1_data1", 32'(st_data[1]), 32'h5678);
         check("f1_spacing", st_cyc[1] - st_cyc[0], 32'd3);
      end
      check("f1_done", 32'(load_done_o), 32'd1);
      check("f1_hold", 32'(cpu_hold_o), 32'd0);
      check("f1_err",  32'(load_error_o), 32'd0);
      check("f1_ready_done", 32'(byte_ready_o), 32'd0);
      rearm();
      check("rearm1_done",  32'(load_done_o), 32'd0);
      check("rearm1_hold",  32'(cpu_hold_o), 32'd1);
      check("rearm1_ready", 32'(byte_ready_o), 32'd1);

      // Bad checksum
      clear_log();
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      send(8'h09);
      check("f2_strobes", st_addr.size(), 32'd2);
      check("f2_err",  32'(load_error_o), 32'd1);
      check("f2_hold", 32'(cpu_hold_o), 32'd1);
      check("f2_done", 32'(load_done_o), 32'd0);
      rearm();
      check("rearm2_err", 32'(load_error_o), 32'd0);

      // Garbage before sync, zero-length frame
      clear_log();
      send(8'h00); send(8'hFF); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      check("f3_strobes", st_addr.size(), 32'd0);
      check("f3_done", 32'(load_done_o), 32'd1);
      check("f3_hold", 32'(cpu_hold_o), 32'd0);
      rearm();

      // Oversize length
      clear_log();
      send(8'hA5); send(8'h01); send(8'h02);
      check("f4_err",     32'(load_error_o), 32'd1);
      check("f4_strobes", st_addr.size(), 32'd0);
      check("f4_ready",   32'(byte_ready_o), 32'd0);
      rearm();
      check("rearm4_err",   32'(load_error_o), 32'd0);
      check("rearm4_hold",  32'(cpu_hold_o), 32'd1);
      check("rearm4_ready", 32'(byte_ready_o), 32'd1);

      // Full-depth frame with random valid gaps
      clear_log();
      ready_in_write = 0;
      ck = 8'h00;
      for (int i = 0; i < 512; i++) begin
         words[i] = 16'(i * 40503) ^ 16'h5A5A;
         ck = ck ^ words[i][7:0] ^ words[i][15:8];
      end
      send(8'hA5); send(8'h00); send(8'h02);
      for (int i = 0; i < 512; i++) begin
         idle($urandom_range(0, 2));
         send(words[i][7:0]);
         idle($urandom_range(0, 2));
         send(words[i][15:8]);
      end
      idle($urandom_range(0, 2));
      send(ck);
      check("f5_strobes", st_addr.size(), 32'd512);
      if (st_addr.size() == 512) begin
         bad = 0;
         for (int i = 0; i < 512; i++) begin
            if (st_addr[i] !== 32'(2 * i) || st_data[i] !== words[i]) bad++;
            if (i > 0 && st_cyc[i] - st_cyc[i-1] < 3) bad++;
         end
         check("f5_words", bad, 32'd0);
         check("f5_last_addr", st_addr[511], 32'h0000_03FE);
      end
      check("f5_ready_in_write", ready_in_write, 32'd0);
      check("f5_done", 32'(load_done_o), 32'd1);
      rearm();

      // Asynchronous reset during DATA_HI
      clear_log();
      send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
      byte_valid_i = 1'b1;
      byte_i       = 8'h12;
      #2 reset_n_i = 1'b0;
      #1;
      check("ar_hold",  32'(cpu_hold_o), 32'd1);
      check("ar_ready", 32'(byte_ready_o), 32'd1);
      check("ar_we",    32'(program_mem_write_en_o), 32'd0);
      check("ar_addr",  instruction_addr_o, 32'h0);
      check("ar_instr", 32'(instruction_o), 32'h0);
      byte_valid_i = 1'b0;
      @(negedge clk_i);
      check("ar_no_strobe", st_addr.size(), 32'd0);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      send(8'hA5); send(8'h01); send(8'h00); send(8'hCD); send(8'hAB); send(8'h66);
      check("f6_strobes", st_addr.size(), 32'd1);
      if (st_addr.size() == 1) begin
         check("f6_addr", st_addr[0], 32'h0);
         check("f6_data", 32'(st_data[0]), 32'hABCD);
      end
      check("f6_done", 32'(load_done_o), 32'd1);
      idle(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side master for the fetch-stage instruction memory port: consumes a framed byte stream over a valid/ready handshake, assembles little-endian halfwords, and issues one write per halfword on the program-memory write interface (write enable, address, instruction data).
- Holds the core in reset until a complete frame passes its checksum.
- Sits between the host serial receiver and the fetch stage.

Parameters:
- MAX_HALFWORDS, 512, maximum halfwords per frame (instruction RAM depth).
- BASE_ADDR, 32'h0000_0000, byte address of the first halfword; must be even.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- reset_n_i  input  1  asynchronous active-low reset.
- byte_valid_i  input  1  host byte valid.
- byte_i  input  8  host byte.
- byte_ready_o  output  1  loader accepts byte_i this cycle.
- load_start_i  input  1  re-arm pulse, honoured only in DONE/ERROR.
- program_mem_write_en_o  output  1  one-cycle write strobe to instruction memory.
- instruction_addr_o  output  32  byte address of the halfword being written.
- instruction_o  output  16  halfword to write.
- cpu_hold_o  output  1  holds core/pipeline in reset while high.
- load_done_o  output  1  frame loaded and checksum good.
- load_error_o  output  1  frame rejected.

Behaviour:
- Interface: one clock clk_i; reset_n_i is asynchronous and active-low. Assertion forces every register immediately; deassertion is sampled on clk_i.
- Reset values:
  - state=SYNC, byte_ready_o=1, program_mem_write_en_o=0.
  - instruction_addr_o=BASE_ADDR, instruction_o=0.
  - cpu_hold_o=1, load_done_o=0, load_error_o=0.
  - Internal count=0, remaining=0, checksum=0.
- Handshake: a byte transfers on a posedge with byte_valid_i && byte_ready_o. byte_ready_o is 1 in SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK, and 0 in WRITE, DONE and ERROR. byte_ready_o is registered from the next state; it never depends combinationally on byte_valid_i.
- Frame: SYNC_BYTE, len[7:0], len[15:8], then 2*len data bytes (low byte first per halfword), then chk. chk is the XOR of all data bytes only.
- States and transitions (on an accepted byte unless noted):
  - SYNC: byte==SYNC_BYTE goes to LEN_LO; any other byte is dropped, state unchanged.
  - LEN_LO: latch len low byte, go to LEN_HI.
  - LEN_HI: form len.
    - len > MAX_HALFWORDS goes to ERROR.
    - len == 0 goes to CHECK.
    - Otherwise remaining=len, instruction_addr_o=BASE_ADDR, go to DATA_LO.
  - DATA_LO: latch low byte, checksum ^= byte, go to DATA_HI.
  - DATA_HI: instruction_o={byte, low}, checksum ^= byte, go to WRITE.
  - WRITE (no byte accepted, exactly 1 cycle): program_mem_write_en_o=1 with instruction_o/instruction_addr_o stable that cycle; remaining decrements. On exit, instruction_addr_o += 2 (32-bit, wraps mod 2^32). Goes to CHECK when remaining reaches 0, else DATA_LO.
  - CHECK: byte==checksum goes to DONE; otherwise ERROR.
  - DONE: load_done_o=1, cpu_hold_o=0.
  - ERROR: load_error_o=1, cpu_hold_o=1.
  - load_start_i in DONE or ERROR returns to SYNC next cycle. That cycle it clears load_done_o/load_error_o and checksum, and sets cpu_hold_o=1.
- program_mem_write_en_o is a registered output, asserted only in WRITE. Latency from the accepted high byte to the strobe is exactly 1 cycle. Minimum spacing between strobes is 3 cycles.
- load_start_i is ignored in all states other than DONE and ERROR, including mid-frame.
- byte_valid_i low in any state stalls the FSM indefinitely with outputs held; there is no timeout.
- Asynchronous reset mid-frame aborts the frame: no further writes, cpu_hold_o=1 immediately. Halfwords already written stay in memory and are not rolled back.
- Memory contents after ERROR are undefined; the core is not released.

Test Plan:
- Reset, then frame A5 02 00 34 12 78 56 chk=0x08: two strobes, addr 0x0000 data 0x1234, then addr 0x0002 data 0x5678, 3 cycles apart. load_done_o=1 and cpu_hold_o=0 one cycle after the chk byte.
- Same frame with chk=0x09: both writes occur, then load_error_o=1, cpu_hold_o stays 1, load_done_o=0.
- Bytes 00 FF A5 00 00 00: leading non-sync bytes are dropped; zero-length frame issues no strobes; chk 0x00 gives load_done_o=1.
- len=0x0201 (513 > 512): ERROR immediately after the len high byte, with no strobes. load_start_i then returns to SYNC with load_error_o=0 and cpu_hold_o=1.
- Full 512-halfword frame with random byte_valid_i gaps: exactly 512 strobes, last address 0x03FE, each data word matching the stimulus, byte_ready_o low in every WRITE cycle.
- reset_n_i asserted asynchronously mid-DATA_HI: outputs return to reset values before the next edge. A new frame after release loads from BASE_ADDR correctly.
